// File: rtl/alu_req_arbiter_pkg.sv
// alu_req_arbiter_pkg: shared ALU function codes, FSM states and error flags
package alu_req_arbiter_pkg;
  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_MUL = 4'b0010;
  localparam logic [3:0] FN_DIV = 4'b0011;
  localparam logic [3:0] FN_CMP = 4'b1100;
  localparam logic [3:0] FN_SHL = 4'b1110;
  localparam logic [3:0] FN_NOP = 4'b1111;
  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_TRAP = 1'b1;
  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;
  function automatic logic is_trap(input logic [3:0] func, input logic b_zero);
    return (func == FN_DIV && b_zero) || func == FN_NOP;
  endfunction
endpackage

// File: rtl/alu_req_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant search starting after the last granted requester
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic               adv,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_vld
);
  logic [ID_W-1:0] last_q, last_d, cand;
  logic hit;
  always_comb begin
    gnt_idx = '0;
    hit = 1'b0;
    cand = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(last_q) + i) % NUM_REQ);
      if (!hit && req[cand]) begin
        hit = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_vld = en && hit;
    gnt = gnt_vld ? NUM_REQ'(1) << gnt_idx : '0;
    last_d = adv ? gnt_idx : last_q;
  end
  always_ff @(posedge clk) last_q <= !rst_n ? ID_W'(NUM_REQ - 1) : last_d;
endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one registered ALU among requesters with a tagged response channel
module alu_req_arbiter
  import alu_req_arbiter_pkg::*;
#(
  parameter int N = 16,
  parameter int NUM_REQ = 4,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*NUM_REQ-1:0] req_func,
  input  logic [N*NUM_REQ-1:0] req_a,
  input  logic [N*NUM_REQ-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [N-1:0]         rsp_data,
  output logic                 rsp_carry,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [N-1:0]         alu_a,
  output logic [N-1:0]         alu_b,
  output logic [3:0]           alu_func,
  input  logic [N-1:0]         alu_out,
  input  logic                 alu_carry
);
  state_t state_q, state_d;
  logic [ID_W-1:0] gnt_idx, id_q, id_d;
  logic gnt_vld;
  logic [N-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_data_q, rsp_data_d, sel_a, sel_b;
  logic [3:0] alu_func_q, alu_func_d, sel_func;
  logic rsp_carry_q, rsp_carry_d, rsp_err_q, rsp_err_d;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .en      (state_q == IDLE),
    .adv     (gnt_vld),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );
  assign sel_func = req_func[int'(gnt_idx)*4 +: 4];
  assign sel_a = req_a[int'(gnt_idx)*N +: N];
  assign sel_b = req_b[int'(gnt_idx)*N +: N];
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    alu_func_d = alu_func_q;
    rsp_data_d = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      IDLE: if (gnt_vld) begin
        id_d = gnt_idx;
        if (is_trap(sel_func, sel_b == '0)) begin
          rsp_data_d = '0;
          rsp_carry_d = 1'b0;
          rsp_err_d = ERR_TRAP;
          state_d = RESP;
        end else begin
          alu_a_d = sel_a;
          alu_b_d = sel_b;
          alu_func_d = sel_func;
          state_d = EXEC;
        end
      end
      EXEC: state_d = CAPT;
      CAPT: begin
        rsp_data_d = alu_out;
        rsp_err_d = ERR_NONE;
        rsp_carry_d = (alu_func_q == FN_ADD || alu_func_q == FN_SUB) ? alu_carry : 1'b0;
        alu_func_d = FN_NOP;
        state_d = RESP;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_func_q <= FN_NOP;
      rsp_data_q <= '0;
      rsp_carry_q <= 1'b0;
      rsp_err_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_func_q <= alu_func_d;
      rsp_data_q <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_valid = state_q == RESP;
  assign busy = state_q != IDLE;
  assign rsp_id = id_q;
  assign rsp_data = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err = rsp_err_q;
  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign alu_func = alu_func_q;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed checks of arbitration, traps, backpressure and reset
module tb_alu_req_arbiter;
  import alu_req_arbiter_pkg::*;
  localparam int N = 16;
  localparam int NR = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  logic [4*NR-1:0] req_func = '0;
  logic [N*NR-1:0] req_a = '0;
  logic [N*NR-1:0] req_b = '0;
  logic rsp_valid, rsp_carry, rsp_err, busy;
  logic rsp_ready = 1'b1;
  logic [1:0] rsp_id;
  logic [N-1:0] rsp_data, alu_a, alu_b;
  logic [N-1:0] alu_out = '0;
  logic alu_carry = 1'b0;
  logic [3:0] alu_func;
  logic [16:0] sum, diff;
  int checks = 0;
  int errs = 0;
  int cyc = 0;
  alu_req_arbiter #(.N(N), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
    .rsp_err(rsp_err), .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_out(alu_out), .alu_carry(alu_carry)
  );
  always #5 clk = ~clk;
  assign sum = {1'b0, alu_a} + {1'b0, alu_b};
  assign diff = {1'b0, alu_a} - {1'b0, alu_b};
  always @(posedge clk) begin
    case (alu_func)
      FN_ADD: alu_out <= sum[15:0];
      FN_SUB: alu_out <= diff[15:0];
      FN_MUL: alu_out <= alu_a * alu_b;
      FN_DIV: alu_out <= (alu_b != 0) ? alu_a / alu_b : 16'hFFFF;
      FN_CMP: alu_out <= (alu_a == alu_b) ? 16'd1 : (alu_a > alu_b) ? 16'd2 : 16'd3;
      default: alu_out <= alu_out;
    endcase
    alu_carry <= (alu_func == FN_ADD) ? sum[16] : diff[16];
  end
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic drive(input int i, input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    req_func[4*i +: 4] = f;
    req_a[N*i +: N] = a;
    req_b[N*i +: N] = b;
    req_valid[i] = 1'b1;
  endtask
  task automatic wait_rsp;
    for (int n = 0; n < 8 && !rsp_valid; n++) tick;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (alu_func !== 4'hF) begin errs++; $display("FAIL reset_alu_func got %h want f", alu_func); end
    checks++; if (alu_a !== 16'h0 || alu_b !== 16'h0) begin errs++; $display("FAIL reset_alu_ab got %h/%h want 0/0", alu_a, alu_b); end
    checks++; if (rsp_data !== 16'h0 || rsp_id !== 2'd0) begin errs++; $display("FAIL reset_rsp got %h id %0d want 0 id 0", rsp_data, rsp_id); end
    checks++; if (rsp_carry !== 1'b0 || rsp_err !== 1'b0) begin errs++; $display("FAIL reset_flags got c%b e%b want c0 e0", rsp_carry, rsp_err); end
    checks++; if (req_ready !== 4'b0000) begin errs++; $display("FAIL reset_ready got %b want 0000", req_ready); end
  endtask
  task automatic test_add;
    drive(0, FN_ADD, 16'hFFFF, 16'h0001);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL add_ready got %b want 0001", req_ready); end
    tick;
    req_valid = '0;
    checks++; if (alu_func !== FN_ADD || alu_a !== 16'hFFFF || alu_b !== 16'h0001) begin errs++; $display("FAIL add_alu_in got f%h a%h b%h want f0 affff b0001", alu_func, alu_a, alu_b); end
    checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin errs++; $display("FAIL add_exec got busy%b vld%b want busy1 vld0", busy, rsp_valid); end
    tick;
    checks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL add_early_valid got %b want 0", rsp_valid); end
    tick;
    checks++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL add_latency got %b want 1", rsp_valid); end
    checks++; if (rsp_data !== 16'h0000 || rsp_id !== 2'd0) begin errs++; $display("FAIL add_data got %h id %0d want 0000 id 0", rsp_data, rsp_id); end
    checks++; if (rsp_carry !== 1'b1 || rsp_err !== 1'b0) begin errs++; $display("FAIL add_flags got c%b e%b want c1 e0", rsp_carry, rsp_err); end
    checks++; if (alu_func !== 4'hF) begin errs++; $display("FAIL add_func_idle got %h want f", alu_func); end
    tick;
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL add_done_busy got %b want 0", busy); end
  endtask
  task automatic test_round_robin;
    logic [3:0] one = 4'b0001;
    logic [15:0] exp_data [4] = '{16'h0003, 16'h0006, 16'h000F, 16'h0123};
    int last = 0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    drive(0, FN_ADD, 16'h0001, 16'h0002);
    drive(1, FN_SUB, 16'h000A, 16'h0004);
    drive(2, FN_MUL, 16'h0003, 16'h0005);
    drive(3, FN_ADD, 16'h0100, 16'h0023);
    for (int k = 0; k < 6; k++) begin
      #1;
      for (int n = 0; n < 8 && req_ready == 0; n++) tick;
      checks++; if (req_ready !== (one << (k % 4))) begin errs++; $display("FAIL rr_order op%0d got %b want %b", k, req_ready, one << (k % 4)); end
      if (k > 0) begin
        checks++; if (cyc - last != 4) begin errs++; $display("FAIL rr_spacing op%0d got %0d want 4", k, cyc - last); end
      end
      last = cyc;
      tick;
      wait_rsp;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_data !== exp_data[k % 4]) begin errs++; $display("FAIL rr_rsp op%0d got v%b id %0d %h want v1 id %0d %h", k, rsp_valid, rsp_id, rsp_data, k % 4, exp_data[k % 4]); end
      tick;
    end
    req_valid = '0;
  endtask
  task automatic test_trap;
    drive(2, FN_DIV, 16'd10, 16'd0);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errs++; $display("FAIL div0_ready got %b want 0100", req_ready); end
    tick;
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errs++; $display("FAIL div0_rsp got v%b e%b want v1 e1", rsp_valid, rsp_err); end
    checks++; if (rsp_data !== 16'h0 || rsp_carry !== 1'b0 || rsp_id !== 2'd2) begin errs++; $display("FAIL div0_data got %h c%b id %0d want 0000 c0 id 2", rsp_data, rsp_carry, rsp_id); end
    checks++; if (alu_func !== 4'hF) begin errs++; $display("FAIL div0_func got %h want f", alu_func); end
    tick;
    checks++; if (alu_func !== 4'hF || busy !== 1'b0) begin errs++; $display("FAIL div0_after got f%h busy%b want ff busy0", alu_func, busy); end
    drive(1, FN_NOP, 16'd5, 16'd5);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errs++; $display("FAIL nop_ready got %b want 0010", req_ready); end
    tick;
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 16'h0) begin errs++; $display("FAIL nop_rsp got v%b e%b id %0d %h want v1 e1 id 1 0000", rsp_valid, rsp_err, rsp_id, rsp_data); end
    checks++; if (alu_func !== 4'hF) begin errs++; $display("FAIL nop_func got %h want f", alu_func); end
    tick;
  endtask
  task automatic test_backpressure;
    rsp_ready = 1'b0;
    drive(3, FN_SUB, 16'd3, 16'd5);
    drive(0, FN_ADD, 16'd7, 16'd8);
    #1;
    checks++; if (req_ready !== 4'b1000) begin errs++; $display("FAIL bp_ready got %b want 1000", req_ready); end
    tick;
    req_valid[3] = 1'b0;
    wait_rsp;
    for (int w = 0; w < 5; w++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hFFFE || rsp_carry !== 1'b1 || rsp_id !== 2'd3 || req_ready !== 4'b0 || busy !== 1'b1) begin errs++; $display("FAIL bp_hold w%0d got v%b %h c%b id %0d rdy %b busy%b want v1 fffe c1 id 3 rdy 0000 busy1", w, rsp_valid, rsp_data, rsp_carry, rsp_id, req_ready, busy); end
      tick;
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errs++; $display("FAIL bp_no_regrant got %b want 0000", req_ready); end
    tick;
    checks++; if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin errs++; $display("FAIL bp_next_grant got %b v%b want 0001 v0", req_ready, rsp_valid); end
    tick;
    req_valid = '0;
    wait_rsp;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'h000F || rsp_carry !== 1'b0) begin errs++; $display("FAIL bp_req0 got v%b id %0d %h c%b want v1 id 0 000f c0", rsp_valid, rsp_id, rsp_data, rsp_carry); end
    tick;
  endtask
  task automatic test_reset_mid;
    drive(1, FN_ADD, 16'd1, 16'd1);
    drive(0, FN_ADD, 16'd2, 16'd2);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errs++; $display("FAIL rmid_ready got %b want 0010", req_ready); end
    tick;
    checks++; if (busy !== 1'b1 || alu_func !== FN_ADD) begin errs++; $display("FAIL rmid_exec got busy%b f%h want busy1 f0", busy, alu_func); end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || alu_func !== 4'hF) begin errs++; $display("FAIL rmid_state got busy%b v%b f%h want busy0 v0 ff", busy, rsp_valid, alu_func); end
    checks++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL rmid_prio got %b want 0001", req_ready); end
    tick;
    req_valid = '0;
    wait_rsp;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'h0004) begin errs++; $display("FAIL rmid_rsp got v%b id %0d %h want v1 id 0 0004", rsp_valid, rsp_id, rsp_data); end
    tick;
  endtask
  task automatic test_mul_cmp;
    drive(1, FN_MUL, 16'h0100, 16'h0100);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errs++; $display("FAIL mul_ready got %b want 0010", req_ready); end
    tick;
    req_valid = '0;
    wait_rsp;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 16'h0000 || rsp_carry !== 1'b0) begin errs++; $display("FAIL mul_rsp got v%b id %0d %h c%b want v1 id 1 0000 c0", rsp_valid, rsp_id, rsp_data, rsp_carry); end
    tick;
    drive(1, FN_CMP, 16'd2, 16'd7);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errs++; $display("FAIL cmp_ready got %b want 0010", req_ready); end
    tick;
    req_valid = '0;
    wait_rsp;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0003 || rsp_carry !== 1'b0 || rsp_err !== 1'b0) begin errs++; $display("FAIL cmp_rsp got v%b %h c%b e%b want v1 0003 c0 e0", rsp_valid, rsp_data, rsp_carry, rsp_err); end
    tick;
  endtask
  initial begin
    test_reset;
    test_add;
    test_round_robin;
    test_trap;
    test_backpressure;
    test_reset_mid;
    test_mul_cmp;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
Round-robin arbiter and sequencer that shares one registered 16-bit ALU instance among NUM_REQ requesters. It accepts one operation at a time over per-requester valid/ready handshakes and drives the ALU operand and function inputs. It captures the ALU's registered result and returns it on a single tagged response channel with carry and error status. Divide-by-zero and the reserved function code are trapped locally and are never issued to the ALU.

Parameters:
N, 16, operand/result width; must match the ALU's N
NUM_REQ, 4, number of requesters (2..8)
ID_W, derived localparam = clog2(NUM_REQ), minimum 1, width of the response tag

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset; synchronous, active-low
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
req_func  in  4*NUM_REQ  ALU function code, requester i at [4i+3:4i]
req_a  in  N*NUM_REQ  operand A, requester i at [N*i+N-1:N*i]
req_b  in  N*NUM_REQ  operand B, same packing as req_a
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_W  index of the requester that owns the response
rsp_data  out  N  result
rsp_carry  out  1  carry/borrow, for ADD/SUB only
rsp_err  out  1  1 = operation trapped (div-by-zero or illegal func)
busy  out  1  high in any state other than IDLE
alu_a  out  N  to ALU A, registered
alu_b  out  N  to ALU B, registered
alu_func  out  4  to ALU_Func, registered; 4'b1111 when not executing
alu_out  in  N  from ALU result register
alu_carry  in  1  from ALU Carry

Behaviour:
- Reset (rst_n=0 at a clock edge) sets:
  - state=IDLE; rsp_valid=0; rsp_id=0; rsp_data=0; rsp_carry=0; rsp_err=0
  - alu_a=0; alu_b=0; alu_func=4'b1111; RR pointer so requester 0 has top priority
- Reset mid-operation: the in-flight op is discarded and no response is produced. The ALU's internal register is not reset; its value is ignored.
- States: IDLE, EXEC, CAPT, RESP.
- IDLE:
  - Grant = first asserted req_valid searching from (last_grant+1) mod NUM_REQ.
  - req_ready[grant]=1, combinational, only in IDLE. The handshake completes when req_valid&req_ready are both high at the edge.
  - On accept, latch the id and update last_grant.
  - If func==4'b0011 and B==0, or func==4'b1111: load rsp_data=0, rsp_carry=0, rsp_err=1, then go to RESP. The ALU is not driven.
  - Otherwise: alu_a<=A, alu_b<=B, alu_func<=func, then go to EXEC.
- EXEC: ALU inputs stable for one cycle; the ALU registers its result at the end of this cycle. Go to CAPT.
- CAPT:
  - rsp_data<=alu_out; rsp_err<=0.
  - rsp_carry<=alu_carry if func is 0000 or 0001, else 0.
  - alu_func<=4'b1111. Go to RESP.
- RESP:
  - rsp_valid=1. All rsp_* outputs held stable while rsp_ready=0.
  - When rsp_ready=1 at the edge, go to IDLE.
  - No same-cycle re-grant from RESP.
- Latency: a normal op has rsp_valid high 3 edges after the accepting edge (accept→EXEC→CAPT→RESP). A trapped op takes 1 edge.
- Throughput: at most one op per 4 cycles (2 for trapped ops).
- Requests arriving outside IDLE are not accepted; all req_ready=0. A requester must hold valid and its data until accepted.
- Width rules:
  - Result is truncated to N bits, as the ALU produces it (MUL keeps the low N bits).
  - Carry is the ALU's bit N from A+B or A−B; a borrow gives carry=1.
  - Compare ops return 1/2/3 or 0, unmodified.
- Simultaneous requests are resolved purely by the RR pointer; a dropped req_valid does not advance the pointer.

Decomposition:
- Shared include/package alu_pkg:
  - func code localparams (FN_ADD=0000 … FN_SHL=1110, FN_NOP=1111)
  - state encoding
  - ERR_NONE/ERR_TRAP
- One sub-module: rr_arbiter (param NUM_REQ).
  - Inputs: req vector, enable, advance.
  - Outputs: one-hot grant and grant index; holds the pointer register.
- The top-level holds the FSM, operand/func registers and the response registers.

Test Plan:
- Req0 ADD A=16'hFFFF B=16'h0001 → accepted; rsp_valid 3 cycles later; rsp_id=0, rsp_data=16'h0000, rsp_carry=1, rsp_err=0.
- All 4 req_valid held high with distinct ops, rsp_ready=1 → acceptance order 0,1,2,3,0,1; one accept every 4 cycles; each rsp_id matches its op.
- Req2 func 0011 A=10 B=0 → rsp_valid 1 cycle after accept; rsp_err=1, rsp_data=0; alu_func stays 4'b1111 throughout. Func 1111 on req1 → same response with rsp_id=1.
- Req3 SUB A=3 B=5, rsp_ready low 5 cycles → rsp_data=16'hFFFE, rsp_carry=1 held stable; req_ready all 0 and busy=1 for the whole wait; a pending req0 is accepted only in the cycle after rsp_ready=1.
- rst_n=0 for one edge while in EXEC → next cycle state IDLE, rsp_valid=0, busy=0, alu_func=4'b1111; with req1 and req0 both valid, req0 is granted first.
- Req1 MUL A=16'h0100 B=16'h0100 then CMP-less (1100) A=2 B=7 → rsp_data=16'h0000 then 16'h0003, both with rsp_carry=0.
